// File: rtl/uart_fsm_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, free-running oversample tick,
// mid-bit start validation, break hold-off after a framing error.
module uart_fsm_rx #(
  parameter int CLK_DIV   = 16,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dataout,
  output logic                 Done,
  output logic                 frame_err,
  output logic                 busy,
  output logic                 tick
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(OVS);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [DW-1:0]        div;
  logic [SW-1:0]        scnt, scnt_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n, dataout_n;
  logic                 done_n, ferr_n;

  // rx is asynchronous; only rx_s is ever looked at by the FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Free-running divider; never realigned to frame edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          div <= '0;
    else if (div == D_LAST) div <= '0;
    else                   div <= div + DW'(1);
  end

  assign tick = (div == D_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      scnt      <= '0;
      bcnt      <= '0;
      shreg     <= '0;
      dataout   <= '0;
      Done      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      scnt      <= scnt_n;
      bcnt      <= bcnt_n;
      shreg     <= shreg_n;
      dataout   <= dataout_n;
      Done      <= done_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n   = state;
    scnt_n    = scnt;
    bcnt_n    = bcnt;
    shreg_n   = shreg;
    dataout_n = dataout;
    done_n    = 1'b0;
    ferr_n    = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_n = START;
            scnt_n  = '0;
          end
        end
        START: begin
          // a low that is gone by mid-bit is a glitch, not a start
          if (scnt == S_MID) begin
            scnt_n = '0;
            bcnt_n = '0;
            state_n = rx_s ? IDLE : DATA;
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
        DATA: begin
          if (scnt == S_END) begin
            scnt_n  = '0;
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            if (bcnt == B_LAST) state_n = STOP;
            else                bcnt_n  = bcnt + BW'(1);
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
        STOP: begin
          if (scnt == S_END) begin
            scnt_n = '0;
            if (rx_s) begin
              dataout_n = shreg;
              done_n    = 1'b1;
              state_n   = IDLE;
            end else begin
              ferr_n  = 1'b1;
              state_n = BRK;
            end
          end else begin
            scnt_n = scnt + SW'(1);
          end
        end
        BRK: begin
          // hold off until the line returns high so a break is not a new start
          if (rx_s) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_fsm_rx.sv
// Directed bench for uart_fsm_rx: expected bytes queued at send time,
// compared against bytes captured on Done.
module tb_uart_fsm_rx;
  localparam int CLK_DIV = 4;
  localparam int OVS     = 16;
  localparam int BIT     = CLK_DIV * OVS;

  logic       clk, reset_n, rx;
  logic [7:0] dataout;
  logic       Done, frame_err, busy, tick;

  uart_fsm_rx #(.CLK_DIV(CLK_DIV), .OVS(OVS), .DATA_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .dataout(dataout),
    .Done(Done), .frame_err(frame_err), .busy(busy), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int rd_idx = 0;
  int start_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int done_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Done) begin
      obs_q.push_back(dataout);
      done_cyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (Done && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
  endtask

  // Transmitter paced by the receiver's own tick, as a paired TX sharing the baud divider would be
  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(negedge clk);
      if (tick) k++;
    end
  endtask

  task automatic tx_byte(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      wait_ticks(OVS);
    end
  endtask

  task automatic expect_byte(input string tag);
    int n;
    logic [7:0] e;
    n = 0;
    while (obs_q.size() <= rd_idx && n < 2000) begin
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    chk({tag, "_arrived"}, 32'(obs_q.size() > rd_idx), 32'd1);
    if (obs_q.size() > rd_idx) begin
      chk(tag, 32'(obs_q[rd_idx]), 32'(e));
      rd_idx++;
    end
  endtask

  initial begin
    int d0, f0;
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dataout", 32'(dataout), 32'h0);
    chk("rst_done", 32'(Done), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    reset_n = 1'b1;
    idle(50);

    // single frame, plus Done latency from the falling edge
    exp_q.push_back(8'hB3);
    send_frame(8'b10110011, 1'b1);
    expect_byte("b3");
    chk("b3_latency_ok", 32'((done_cyc[0] - start_cyc) >= 606 && (done_cyc[0] - start_cyc) <= 614), 32'd1);
    chk("b3_busy_after", 32'(busy), 32'd0);
    chk("b3_ferr", 32'(ferr_cnt), 32'd0);
    idle(100);

    // back-to-back frames, zero idle gap
    d0 = done_cyc.size();
    exp_q.push_back(8'hCC);
    exp_q.push_back(8'h00);
    send_frame(8'b11001100, 1'b1);
    send_frame(8'h00, 1'b1);
    expect_byte("b2b_cc");
    expect_byte("b2b_00");
    chk("b2b_count", 32'(done_cyc.size() - d0), 32'd2);
    if (done_cyc.size() >= d0 + 2)
      chk("b2b_spacing_ok", 32'((done_cyc[d0+1] - done_cyc[d0]) >= BIT*10 - 4 &&
                                (done_cyc[d0+1] - done_cyc[d0]) <= BIT*10 + 4), 32'd1);
    idle(100);

    // 20-clk glitch is rejected, then a valid frame
    d0 = obs_q.size();
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (20) @(negedge clk);
    idle(100);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_nodone", 32'(obs_q.size()), 32'(d0));
    chk("glitch_noferr", 32'(ferr_cnt), 32'(f0));
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    expect_byte("after_glitch_5a");
    idle(100);

    // bad stop bit, line held low, then recovery
    d0 = obs_q.size();
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b0);
    rx = 1'b0;
    repeat (3 * BIT) @(negedge clk);
    idle(200);
    chk("ferr_pulse", 32'(ferr_cnt), 32'(f0 + 1));
    chk("ferr_nodone", 32'(obs_q.size()), 32'(d0));
    chk("ferr_hold", 32'(dataout), 32'h5A);
    chk("ferr_busy", 32'(busy), 32'd0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    expect_byte("after_ferr_3c");
    idle(100);

    // reset in the middle of DATA
    d0 = obs_q.size();
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mrst_dataout", 32'(dataout), 32'h0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_tick", 32'(tick), 32'd0);
    repeat (10) @(negedge clk);
    reset_n = 1'b1;
    idle(200);
    chk("mrst_nodone", 32'(obs_q.size()), 32'(d0));
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    expect_byte("after_rst_81");
    idle(100);

    // tick-paced transmitter looped into rx
    d0 = obs_q.size();
    exp_q.push_back(8'hB3);
    exp_q.push_back(8'hCC);
    tx_byte(8'hB3);
    tx_byte(8'hCC);
    expect_byte("loop_b3");
    expect_byte("loop_cc");
    idle(100);
    chk("loop_count", 32'(obs_q.size() - d0), 32'd2);
    chk("never_both", 32'(both_cnt), 32'd0);
    chk("total_ferr", 32'(ferr_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
